// File: rtl/freq_down_counter.sv
// Reloadable APU waveform down-counter: counts (PERIOD_BASE - freq) ticks per period,
// strobes expire on each period end and advances a duty-step index.
module freq_down_counter #(
  parameter int WIDTH       = 11,
  parameter int PERIOD_BASE = 2**WIDTH,
  parameter int STEPS       = 8,
  localparam int CW         = $clog2(PERIOD_BASE) + 1,
  localparam int SW         = $clog2(STEPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             trigger,
  input  logic             freq_we,
  input  logic [WIDTH-1:0] freq_in,
  output logic [CW-1:0]    count,
  output logic [SW-1:0]    step,
  output logic             running,
  output logic             expire,
  output logic             step_wrap,
  output logic [WIDTH-1:0] freq
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  freq_eff;
  logic [CW-1:0]     reload;
  logic              last_step;

  // A same-cycle write takes effect on a reload happening in that cycle.
  assign freq_eff  = freq_we ? freq_in : freq;
  assign reload    = CW'(PERIOD_BASE) - {{(CW-WIDTH){1'b0}}, freq_eff};
  assign last_step = (step == SW'(STEPS - 1));
  assign running   = (state_q == RUN);

  always_comb begin
    state_d   = state_q;
    expire    = 1'b0;
    step_wrap = 1'b0;
    if (trigger)
      state_d = RUN;
    else if (tick && running && (count == CW'(1)))
      expire = 1'b1;
    step_wrap = expire && last_step;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      freq    <= '0;
      count   <= CW'(PERIOD_BASE);
      step    <= '0;
    end else begin
      state_q <= state_d;
      if (freq_we)
        freq <= freq_in;
      if (trigger) begin
        count <= reload;
        step  <= '0;
      end else if (tick && running) begin
        if (expire) begin
          count <= reload;
          step  <= last_step ? '0 : step + SW'(1);
        end else begin
          count <= count - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_freq_down_counter.sv
// Directed self-checking bench for freq_down_counter.
module tb_freq_down_counter;

  logic        clk = 1'b0;
  logic        reset, tick, trigger, freq_we;
  logic [10:0] freq_in;
  logic [11:0] count;
  logic [2:0]  step;
  logic        running, expire, step_wrap;
  logic [10:0] freq;

  int n_cmp = 0, n_bad = 0;
  logic last_exp, last_wrap;

  freq_down_counter dut (
    .clk(clk), .reset(reset), .tick(tick), .trigger(trigger),
    .freq_we(freq_we), .freq_in(freq_in), .count(count), .step(step),
    .running(running), .expire(expire), .step_wrap(step_wrap), .freq(freq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, sample combinational strobes before the edge,
  // then return 1ns after the edge with inputs released.
  task automatic cyc(input logic t, input logic trg, input logic we, input logic [10:0] fi);
    tick = t; trigger = trg; freq_we = we; freq_in = fi;
    #2;
    last_exp  = expire;
    last_wrap = step_wrap;
    @(posedge clk); #1;
    tick = 1'b0; trigger = 1'b0; freq_we = 1'b0; freq_in = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int nexp, first, second;
    reset = 1'b1; tick = 1'b0; trigger = 1'b0; freq_we = 1'b0; freq_in = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Idle after reset
    chk("rst_count", count, 2048);
    chk("rst_step", step, 0);
    chk("rst_running", running, 0);
    chk("rst_freq", freq, 0);
    chk("rst_expire", expire, 0);
    chk("rst_wrap", step_wrap, 0);
    nexp = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 0, 0);
      nexp += last_exp;
    end
    chk("idle_expires", nexp, 0);
    chk("idle_count", count, 2048);
    chk("idle_running", running, 0);

    // Period 3
    cyc(0, 0, 1, 11'd2045);
    chk("p3_freq", freq, 2045);
    chk("p3_count_undisturbed", count, 2048);
    cyc(0, 1, 0, 0);
    chk("p3_trig_expire", last_exp, 0);
    chk("p3_trig_count", count, 3);
    chk("p3_running", running, 1);
    cyc(1, 0, 0, 0);
    chk("p3_t1_exp", last_exp, 0);
    chk("p3_t1_count", count, 2);
    cyc(1, 0, 0, 0);
    chk("p3_t2_exp", last_exp, 0);
    chk("p3_t2_count", count, 1);
    cyc(1, 0, 0, 0);
    chk("p3_t3_exp", last_exp, 1);
    chk("p3_t3_count", count, 3);
    chk("p3_t3_step", step, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0);
      chk("p3_rep_exp", last_exp, (i == 2) ? 1 : 0);
    end
    chk("p3_rep_step", step, 2);

    // Period 1 with step wrap
    cyc(0, 0, 1, 11'd2047);
    cyc(0, 1, 0, 0);
    chk("p1_trig_count", count, 1);
    chk("p1_trig_step", step, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0, 0);
      chk("p1_exp", last_exp, 1);
      chk("p1_wrap", last_wrap, (i == 7) ? 1 : 0);
      chk("p1_step", step, (i + 1) % 8);
      chk("p1_count", count, 1);
    end

    // Mid-period frequency write
    cyc(0, 0, 1, 11'd2040);
    cyc(0, 1, 0, 0);
    chk("mid_trig_count", count, 8);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("mid_count_2", count, 6);
    cyc(0, 0, 1, 11'd2046);
    chk("mid_count_hold", count, 6);
    chk("mid_freq", freq, 2046);
    first = 0; second = 0;
    for (int i = 3; i <= 12; i++) begin
      cyc(1, 0, 0, 0);
      if (last_exp) begin
        if (first == 0) first = i;
        else if (second == 0) second = i;
      end
    end
    chk("mid_first_exp", first, 8);
    chk("mid_second_exp", second, 10);
    cyc(0, 1, 1, 11'd2000);
    chk("we_trig_count", count, 48);
    chk("we_trig_freq", freq, 2000);

    // Trigger and tick together at count==1
    cyc(0, 0, 1, 11'd2045);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
    chk("tt_pre_count", count, 1);
    chk("tt_pre_step", step, 1);
    cyc(1, 1, 0, 0);
    chk("tt_expire", last_exp, 0);
    chk("tt_count", count, 3);
    chk("tt_step", step, 0);

    // Reset mid-period
    cyc(1, 0, 0, 0);
    do_reset();
    chk("mrst_count", count, 2048);
    chk("mrst_step", step, 0);
    chk("mrst_running", running, 0);
    chk("mrst_freq", freq, 0);

    // freq = 0: period 2048
    cyc(0, 1, 0, 0);
    chk("f0_count", count, 2048);
    first = 0; second = 0;
    for (int i = 1; i <= 4096; i++) begin
      cyc(1, 0, 0, 0);
      if (last_exp) begin
        if (first == 0) first = i;
        else if (second == 0) second = i;
      end
    end
    chk("f0_first_exp", first, 2048);
    chk("f0_second_exp", second, 4096);
    chk("f0_step", step, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
